vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning); all timing parameters are in pixels (horizontal) or lines (vertical):
- H_VISIBLE, 800, visible pixels per line.
- H_FRONT, 40, horizontal front porch.
- H_SYNC, 128, horizontal sync width.
- H_BACK, 88, horizontal back porch.
- V_VISIBLE, 600, visible lines per frame.
- V_FRONT, 1, vertical front porch.
- V_SYNC, 4, vertical sync width.
- V_BACK, 23, vertical back porch.
- SYNC_POL, 1, sync active level (1 = active-high).
REQ-002 Ports, one per line (name, direction, width, meaning):
- i_clk, input, 1, single clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_pix_en, input, 1, pixel tick; all state advances only on i_clk edges where i_pix_en=1.
- o_h_coord, output, 11, horizontal coordinate to the pixel renderers.
- o_v_coord, output, 10, vertical coordinate to the pixel renderers.
- o_disp_enbl, output, 1, coordinate is inside the visible area.
- o_frame_start, output, 1, one-cycle pulse at the start of each frame.
- i_red, input, 4, renderer red for the current coordinate.
- i_green, input, 4, renderer green for the current coordinate.
- i_blue, input, 4, renderer blue for the current coordinate.
- o_vga_red, output, 4, registered red to the VGA pins.
- o_vga_green, output, 4, registered green to the VGA pins.
- o_vga_blue, output, 4, registered blue to the VGA pins.
- o_hsync, output, 1, horizontal sync to the VGA pins.
- o_vsync, output, 1, vertical sync to the VGA pins.

Function
REQ-003 Line and frame lengths: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (1056) and V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (628).
REQ-004 Horizontal counter h_cnt SHALL count 0 to H_TOTAL-1 on each pix_en and wrap to 0.
REQ-005 Vertical counter v_cnt SHALL increment only on the pix_en where h_cnt wraps, and SHALL itself wrap from V_TOTAL-1 to 0.
REQ-006 Stage 0: on each pix_en, register the following from the pre-increment counters:
- o_h_coord <= h_cnt and o_v_coord <= v_cnt.
- o_disp_enbl <= (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- raw hsync active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [840, 968).
- raw vsync active for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [601, 605).
REQ-007 Coordinates SHALL keep counting through blanking (o_h_coord up to 1055, o_v_coord up to 627); renderers gate on o_disp_enbl.
REQ-008 Stage 1: on each pix_en, o_vga_red/green/blue <= o_disp_enbl ? i_red/green/blue : 0, and o_hsync/o_vsync <= raw syncs XOR !SYNC_POL. Colour and syncs therefore emerge aligned.
REQ-009 Total latency from counter value to pins SHALL be 2 pix_en ticks. The renderer path i_* SHALL be combinational from the stage-0 outputs within one clock.
REQ-010 o_frame_start SHALL be high for exactly one i_clk cycle: the cycle after the pix_en that loads coordinate (0,0) into stage 0. It SHALL be low otherwise, including when i_pix_en is held high.
REQ-011 With i_pix_en=0, all registers SHALL hold and o_frame_start SHALL be 0.
REQ-012 Counter comparisons SHALL use widths of 11 bits (h) and 10 bits (v); no truncation is permitted for the default parameters.

Reset
REQ-013 While i_rst_n=0, asynchronously: h_cnt=0, v_cnt=0, o_h_coord=0, o_v_coord=0, o_disp_enbl=0, o_frame_start=0, all o_vga colours 0, o_hsync/o_vsync at the inactive level.
REQ-014 Reset asserted mid-frame SHALL abort the frame immediately. After release, the first pix_en SHALL load (0,0) into stage 0 and raise o_frame_start.

Structure
REQ-015 Package vga_pkg SHALL hold the 800x600@60 timing constants (defaults above), the H_TOTAL/V_TOTAL derivations, and the coordinate width constants (11, 10).
REQ-016 One sub-module, vga_axis_counter (parameter TOTAL; inputs enable; outputs count, wrap), SHALL be instantiated twice: once for h and once for v, where the v instance is enabled by h wrap && pix_en.

Verification
REQ-017 Directed scenarios a bench must cover:
- pix_en tied 1, release reset: o_frame_start at cycle 1; o_hsync first high at the pix_en that presents h_cnt=840 two ticks earlier; hsync high 128 ticks, period 1056 ticks.
- Full frame, pix_en tied 1: o_vsync high for 4x1056 ticks, period 628x1056 = 663168 ticks; exactly one o_frame_start per frame.
- i_red/green/blue = 4'hF constant: o_vga colours 4'hF for exactly 800 ticks per visible line; 0 during h blanking and on lines 600..627.
- pix_en asserted every 2nd clock: all periods double in clocks; outputs stable on non-pix_en clocks; o_frame_start width still 1 clock.
- Reset asserted at h=500, v=300: all outputs go to reset values the same cycle without waiting for a clock edge; after release, coordinates restart at (0,0).
- SYNC_POL=0: o_hsync/o_vsync idle 1, active 0, timing otherwise identical to the first scenario.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600@60 timing constants and coordinate widths
package vga_pkg;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BACK    = 88;
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BACK    = 23;
    localparam int VGA_SYNC_POL  = 1;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int H_W = 11;
    localparam int V_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - modulo-TOTAL counter with terminal-count flag
module vga_axis_counter #(
    parameter int TOTAL = 1056,
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    // wrap flags the last count; the next enabled edge returns to zero
    assign wrap = (count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, coordinate stage and pin stage
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int SYNC_POL  = VGA_SYNC_POL
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_en,
    output logic [H_W-1:0] o_h_coord,
    output logic [V_W-1:0] o_v_coord,
    output logic           o_disp_enbl,
    output logic           o_frame_start,
    input  logic [3:0]     i_red,
    input  logic [3:0]     i_green,
    input  logic [3:0]     i_blue,
    output logic [3:0]     o_vga_red,
    output logic [3:0]     o_vga_green,
    output logic [3:0]     o_vga_blue,
    output logic           o_hsync,
    output logic           o_vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic           SYNC_IDLE  = (SYNC_POL == 0);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap;
    logic           v_wrap;
    logic           at_origin;
    logic           raw_hsync;
    logic           raw_vsync;

    vga_axis_counter #(.TOTAL(H_TOTAL), .WIDTH(H_W)) u_h_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (i_pix_en),
        .count   (h_cnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .WIDTH(V_W)) u_v_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (h_wrap && i_pix_en),
        .count   (v_cnt),
        .wrap    (v_wrap)
    );

    // at_origin tracks counters == (0,0) so the frame pulse needs no wide compare
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            at_origin     <= 1'b1;
            o_h_coord     <= '0;
            o_v_coord     <= '0;
            o_disp_enbl   <= 1'b0;
            o_frame_start <= 1'b0;
            raw_hsync     <= 1'b0;
            raw_vsync     <= 1'b0;
        end else begin
            o_frame_start <= i_pix_en && at_origin;
            if (i_pix_en) begin
                at_origin   <= h_wrap && v_wrap;
                o_h_coord   <= h_cnt;
                o_v_coord   <= v_cnt;
                o_disp_enbl <= (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
                raw_hsync   <= (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
                raw_vsync   <= (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
            end
        end
    end

    // pin stage: colour and syncs leave together, one tick behind the coordinates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vga_red   <= 4'h0;
            o_vga_green <= 4'h0;
            o_vga_blue  <= 4'h0;
            o_hsync     <= SYNC_IDLE;
            o_vsync     <= SYNC_IDLE;
        end else if (i_pix_en) begin
            o_vga_red   <= o_disp_enbl ? i_red   : 4'h0;
            o_vga_green <= o_disp_enbl ? i_green : 4'h0;
            o_vga_blue  <= o_disp_enbl ? i_blue  : 4'h0;
            o_hsync     <= raw_hsync ^ SYNC_IDLE;
            o_vsync     <= raw_vsync ^ SYNC_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 5, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [3:0] red = 4'h0, green = 4'h0, blue = 4'h0;

    logic [10:0] a_h, n_h, d_h;
    logic [9:0]  a_v, n_v, d_v;
    logic        a_de, n_de, d_de, a_fs, n_fs, d_fs;
    logic [3:0]  a_r, a_g, a_b, n_r, n_g, n_b, d_r, d_g, d_b;
    logic        a_hs, a_vs, n_hs, n_vs, d_hs, d_vs;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                     .SYNC_POL(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_h_coord(a_h), .o_v_coord(a_v), .o_disp_enbl(a_de), .o_frame_start(a_fs),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_vga_red(a_r), .o_vga_green(a_g), .o_vga_blue(a_b),
        .o_hsync(a_hs), .o_vsync(a_vs)
    );

    vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                     .SYNC_POL(0)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_h_coord(n_h), .o_v_coord(n_v), .o_disp_enbl(n_de), .o_frame_start(n_fs),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_vga_red(n_r), .o_vga_green(n_g), .o_vga_blue(n_b),
        .o_hsync(n_hs), .o_vsync(n_vs)
    );

    vga_timing_gen dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_h_coord(d_h), .o_v_coord(d_v), .o_disp_enbl(d_de), .o_frame_start(d_fs),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_vga_red(d_r), .o_vga_green(d_g), .o_vga_blue(d_b),
        .o_hsync(d_hs), .o_vsync(d_vs)
    );

    typedef struct {
        int h; int v; bit de; bit fs;
        bit [3:0] r; bit [3:0] g; bit [3:0] b;
        bit hs; bit vs;
    } exp_t;

    typedef struct {
        string name; int cycles; int period; int colour;
    } phase_t;

    exp_t   sb[$];
    exp_t   cur;
    phase_t phases[4];
    int     checks = 0, errors = 0, cyc = 0;

    int m_h, m_v, s0_h, s0_v;
    bit s0_de, s0_hs, s0_vs;

    bit track_d = 1'b0;
    int d_edge = 0, d_rise1 = 0, d_fall1 = 0, d_rise2 = 0, d_cols = 0, d_hmax = 0;
    int d_fscnt = 0, a_fscnt = 0;
    bit d_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; s0_h = 0; s0_v = 0;
        s0_de = 0; s0_hs = 0; s0_vs = 0;
        cur = '{default: 0};
    endtask

    // Reference raster: counters feed a coordinate stage, which feeds the pin stage
    task automatic model_tick(input bit p, input bit [3:0] r, input bit [3:0] g, input bit [3:0] b);
        cur.fs = 0;
        if (p) begin
            cur.r  = s0_de ? r : 4'h0;
            cur.g  = s0_de ? g : 4'h0;
            cur.b  = s0_de ? b : 4'h0;
            cur.hs = s0_hs;
            cur.vs = s0_vs;
            cur.fs = (m_h == 0) && (m_v == 0);
            s0_h  = m_h;
            s0_v  = m_v;
            s0_de = (m_h < HV) && (m_v < VV);
            s0_hs = (m_h >= HV + HF) && (m_h < HV + HF + HS);
            s0_vs = (m_v >= VV + VF) && (m_v < VV + VF + VS);
            cur.h = s0_h; cur.v = s0_v; cur.de = s0_de;
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
    endtask

    task automatic step(input bit p, input bit [3:0] r, input bit [3:0] g, input bit [3:0] b);
        exp_t e;
        pix_en = p; red = r; green = g; blue = b;
        model_tick(p, r, g, b);
        sb.push_back(cur);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e = sb.pop_front();
        chk("h_coord", a_h, e.h);
        chk("v_coord", a_v, e.v);
        chk("disp_enbl", a_de, e.de);
        chk("frame_start", a_fs, e.fs);
        chk("vga_red", a_r, e.r);
        chk("vga_green", a_g, e.g);
        chk("vga_blue", a_b, e.b);
        chk("hsync", a_hs, e.hs);
        chk("vsync", a_vs, e.vs);
        chk("neg_hsync", n_hs, !e.hs);
        chk("neg_vsync", n_vs, !e.vs);
        chk("neg_coord", {n_v, n_h, n_de, n_fs}, {e.v[9:0], e.h[10:0], e.de, e.fs});
        chk("neg_colour", {n_r, n_g, n_b}, {e.r, e.g, e.b});
    endtask

    // Default-geometry instance: edge index = pix_en ticks since reset release
    always @(posedge clk) begin
        if (track_d) begin
            d_edge++;
            #1;
            if (d_hs && !d_prev) begin
                if (d_rise1 == 0) d_rise1 = d_edge;
                else if (d_rise2 == 0) d_rise2 = d_edge;
            end
            if (!d_hs && d_prev && d_fall1 == 0) d_fall1 = d_edge;
            d_prev = d_hs;
            if (d_edge <= 1056 && d_r == 4'hF) d_cols++;
            if (int'(d_h) > d_hmax) d_hmax = int'(d_h);
            if (d_fs) d_fscnt++;
            if (a_fs) a_fscnt++;
        end
    end

    initial begin
        bit found;
        phases[0] = '{"tied", 1900, 1, 15};
        phases[1] = '{"half", 480, 2, 9};
        phases[2] = '{"rand", 400, 0, -1};
        phases[3] = '{"third", 210, 3, -1};

        model_reset();
        #12;
        chk("rst_h_coord", a_h, 0);
        chk("rst_fs", a_fs, 0);
        chk("rst_hsync", a_hs, 0);
        chk("rst_neg_hsync", n_hs, 1);
        chk("rst_neg_vsync", n_vs, 1);
        chk("rst_d_state", {d_v, d_de, d_g, d_b, d_vs}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        track_d = 1'b1;
        for (int pi = 0; pi < 4; pi++) begin
            for (int c = 0; c < phases[pi].cycles; c++) begin
                bit p;
                bit [3:0] col;
                p   = (phases[pi].period == 0) ? 1'($urandom_range(0, 1))
                                               : ((c % phases[pi].period) == 0);
                col = (phases[pi].colour < 0) ? 4'($urandom_range(0, 15))
                                              : 4'(phases[pi].colour);
                step(p, col, ~col, col ^ 4'h5);
            end
            if (pi == 0) begin
                track_d = 1'b0;
                chk("d_hsync_first_rise", d_rise1, 842);
                chk("d_hsync_first_fall", d_fall1, 970);
                chk("d_hsync_second_rise", d_rise2, 842 + 1056);
                chk("d_colour_ticks_line0", d_cols, 800);
                chk("d_h_coord_max", d_hmax, 1055);
                chk("d_frame_starts", d_fscnt, 1);
                chk("frame_starts_12", a_fscnt, 12);
            end
        end

        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_h == 5 && m_v == 3) found = 1;
            else step(1, 4'hF, 4'hF, 4'hF);
        end
        chk("seek_mid_frame", found, 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_h_coord", a_h, 0);
        chk("async_v_coord", a_v, 0);
        chk("async_de_fs", {a_de, a_fs}, 0);
        chk("async_colour", {a_r, a_g, a_b}, 0);
        chk("async_syncs", {a_hs, a_vs}, 0);
        chk("async_neg_syncs", {n_hs, n_vs}, 3);
        chk("async_d_h_coord", d_h, 0);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sb.delete();
        step(1, 4'h3, 4'h3, 4'h3);
        chk("rel_h_coord", a_h, 0);
        chk("rel_frame_start", a_fs, 1);
        step(1, 4'h3, 4'h3, 4'h3);
        chk("rel_frame_start_low", a_fs, 0);
        chk("rel_h_coord_next", a_h, 1);
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 4'h6, 4'h6, 4'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
